// File: rtl/f_encoder.sv
// Multi-hot to binary index encoder: emits each legal set bit, lowest first, one beat per handshake.
// First beat 1 cycle after capture; beats hold under OUT_READY=0, IN_READY low while draining.
module f_encoder #(
    parameter int WIDTH       = 32,
    parameter int IDXW        = 5,
    parameter int VALID_LINES = 17
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN,
    output logic [IDXW-1:0]  OUT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             OUT_LAST,
    output logic             ERR,
    output logic             EMPTY
);

    typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] MASK = (VALID_LINES >= WIDTH) ? '1 : ((ONE << VALID_LINES) - ONE);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [IDXW-1:0]  out_q, out_d;
    logic             out_vld_q, out_vld_d;
    logic             out_last_q, out_last_d;
    logic             err_q, err_d;
    logic             empty_q, empty_d;

    logic [WIDTH-1:0] masked_in;
    logic [WIDTH-1:0] pending_next;

    // Descending scan so the final assignment is the lowest set index.
    function automatic logic [IDXW-1:0] lowest_idx(input logic [WIDTH-1:0] v);
        lowest_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = IDXW'(i);
        end
    endfunction

    function automatic logic single_bit(input logic [WIDTH-1:0] v);
        single_bit = (v != '0) && ((v & (v - ONE)) == '0);
    endfunction

    assign masked_in    = IN & MASK;
    assign pending_next = pending_q & ~(ONE << out_q);

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        out_last_d = out_last_q;
        err_d      = err_q;
        empty_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    pending_d = masked_in;
                    err_d     = |(IN & ~MASK);
                    if (masked_in == '0) begin
                        empty_d = 1'b1;
                    end else begin
                        state_d    = DRAIN;
                        out_d      = lowest_idx(masked_in);
                        out_vld_d  = 1'b1;
                        out_last_d = single_bit(masked_in);
                    end
                end
            end
            DRAIN: begin
                if (out_vld_q && OUT_READY) begin
                    pending_d = pending_next;
                    if (out_last_q) begin
                        state_d    = IDLE;
                        out_vld_d  = 1'b0;
                        out_last_d = 1'b0;
                    end else begin
                        out_d      = lowest_idx(pending_next);
                        out_last_d = single_bit(pending_next);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            err_q      <= 1'b0;
            empty_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
            err_q      <= err_d;
            empty_q    <= empty_d;
        end
    end

    assign IN_READY  = (state_q == IDLE);
    assign OUT       = out_q;
    assign OUT_VALID = out_vld_q;
    assign OUT_LAST  = out_last_q;
    assign ERR       = err_q;
    assign EMPTY     = empty_q;

endmodule

// File: tb/tb_f_encoder.sv
// Directed bench for f_encoder: inputs driven and outputs sampled on the falling clock edge.
module tb_f_encoder;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] IN;
    logic [4:0]  OUT;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic        OUT_LAST;
    logic        ERR;
    logic        EMPTY;

    int n_cmp = 0;
    int n_err = 0;

    f_encoder #(.WIDTH(32), .IDXW(5), .VALID_LINES(17)) dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN(IN),
        .OUT(OUT), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_LAST(OUT_LAST), .ERR(ERR), .EMPTY(EMPTY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Checks the full output bundle in one call.
    task automatic check_out(input string tag, input logic vld, input logic [4:0] idx,
                             input logic last, input logic rdy, input logic err);
        check({tag, ".vld"},  32'(OUT_VALID), 32'(vld));
        if (vld) check({tag, ".out"}, 32'(OUT), 32'(idx));
        check({tag, ".last"}, 32'(OUT_LAST), 32'(last));
        check({tag, ".rdy"},  32'(IN_READY), 32'(rdy));
        check({tag, ".err"},  32'(ERR), 32'(err));
    endtask

    initial begin
        int multi_exp[4];
        multi_exp[0] = 0; multi_exp[1] = 2; multi_exp[2] = 5; multi_exp[3] = 16;

        RST = 1'b0; IN_VALID = 1'b0; IN = '0; OUT_READY = 1'b1;
        #12;
        check("rst.out", 32'(OUT), 32'd0);
        check_out("rst", 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("rst.empty", 32'(EMPTY), 32'd0);
        @(negedge CLK); RST = 1'b1;

        // Single bit
        IN = 32'h0000_0400; IN_VALID = 1'b1;
        @(negedge CLK);
        check_out("single.beat", 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
        IN_VALID = 1'b0;
        @(negedge CLK);
        check_out("single.after", 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("single.outhold", 32'(OUT), 32'd10);

        // Multi-bit, lowest index first
        IN = 32'h0001_0025; IN_VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            IN_VALID = 1'b0;
            check_out($sformatf("multi.b%0d", i), 1'b1, 5'(multi_exp[i]), (i == 3), 1'b0, 1'b0);
        end
        @(negedge CLK);
        check_out("multi.after", 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);

        // Out-of-range only: empty
        IN = 32'h8002_0000; IN_VALID = 1'b1;
        @(negedge CLK);
        IN_VALID = 1'b0;
        check("empty.pulse", 32'(EMPTY), 32'd1);
        check_out("empty.cap", 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        @(negedge CLK);
        check("empty.gone", 32'(EMPTY), 32'd0);
        check_out("empty.next", 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);

        // Mixed legal and out-of-range
        IN = 32'h0010_0008; IN_VALID = 1'b1;
        @(negedge CLK);
        IN_VALID = 1'b0;
        check_out("mixed.beat", 1'b1, 5'd3, 1'b1, 1'b0, 1'b1);
        check("mixed.empty", 32'(EMPTY), 32'd0);
        @(negedge CLK);
        check_out("mixed.after", 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);

        // Backpressure
        IN = 32'h0000_0003; IN_VALID = 1'b1; OUT_READY = 1'b0;
        @(negedge CLK);
        IN_VALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_out($sformatf("bp.hold%0d", i), 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
            if (i < 3) @(negedge CLK);
        end
        OUT_READY = 1'b1;
        @(negedge CLK);
        check_out("bp.b1", 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        check_out("bp.after", 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);

        // Reset mid-drain
        IN = 32'h0000_FFFF; IN_VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            IN_VALID = 1'b0;
            check_out($sformatf("rstmid.b%0d", i), 1'b1, 5'(i), 1'b0, 1'b0, 1'b0);
        end
        #1 RST = 1'b0;
        #1;
        check("rstmid.out", 32'(OUT), 32'd0);
        check_out("rstmid.forced", 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        @(negedge CLK); RST = 1'b1;
        @(negedge CLK);
        check_out("rstmid.release", 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        IN = 32'h0000_0001; IN_VALID = 1'b1;
        @(negedge CLK);
        IN_VALID = 1'b0;
        check_out("rstmid.new", 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        check_out("rstmid.after", 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);

        // Back-to-back vectors with IN_VALID held
        IN = 32'h0000_0006; IN_VALID = 1'b1;
        @(negedge CLK);
        IN = 32'h0000_0001;
        check_out("b2b.b0", 1'b1, 5'd1, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        check_out("b2b.b1", 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        check_out("b2b.idle", 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        @(negedge CLK);
        IN_VALID = 1'b0;
        check_out("b2b.b2", 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        check_out("b2b.after", 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/f_encoder.md
# f_encoder

Sequential one-hot/multi-hot to binary encoder for the floating ALU select path, the inverse of the 5-to-32 select decoder F_Decoder. It accepts a 32-bit request vector over a valid/ready handshake. It emits the 5-bit index of each set bit, lowest index first, one beat per output handshake. Only lines 0..VALID_LINES-1 are legal select lines; higher bits are dropped and flagged.

## Interface
- WIDTH, 32: request vector width.
- IDXW, 5: index width; WIDTH = 2**IDXW.
- VALID_LINES, 17: number of legal select lines (indices 0..16).
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  reset, asynchronous, active-low.
- IN_VALID  input  1  request vector IN is valid.
- IN_READY  output  1  encoder can accept a vector.
- IN  input  WIDTH  request vector; bit i requests index i.
- OUT  output  IDXW  encoded index of the current beat.
- OUT_VALID  output  1  OUT holds a valid index.
- OUT_READY  input  1  consumer accepts the current beat.
- OUT_LAST  output  1  current beat is the final set bit of the vector.
- ERR  output  1  captured vector had a bit set at an index >= VALID_LINES.
- EMPTY  output  1  one-cycle pulse: captured vector had no legal bits set.

## Operation
- The FSM has two states: IDLE and DRAIN. IN_READY = 1 in IDLE only.
- Reset values: state IDLE, pending vector 0, OUT = 0, OUT_VALID = 0, OUT_LAST = 0, ERR = 0, EMPTY = 0.
- Capture: occurs in IDLE when IN_VALID && IN_READY.
  - pending <= IN & mask, where mask has bits 0..VALID_LINES-1 set.
  - ERR <= |(IN & ~mask).
  - If the masked vector is 0: stay in IDLE, pulse EMPTY for one cycle, and keep OUT_VALID at 0.
  - Otherwise go to DRAIN. Load OUT with the lowest set index of the masked vector and set OUT_VALID = 1. Set OUT_LAST = 1 if exactly one bit is set.
- DRAIN behaviour:
  - OUT, OUT_VALID and OUT_LAST are registers.
  - They hold steady while OUT_READY = 0.
  - On OUT_VALID && OUT_READY, clear bit OUT in pending.
  - If OUT_LAST was 1: go to IDLE and set OUT_VALID = 0 and OUT_LAST = 0. OUT keeps its last value.
  - Otherwise: OUT <= lowest set index of the updated pending vector, and OUT_LAST <= (exactly one bit remains).
- Priority: a lower index always precedes a higher one. The indices of one vector are emitted in strictly increasing order, and each set bit is emitted exactly once.
- ERR holds its value from capture until the next capture or reset. EMPTY is high only in the cycle after a capture with no legal bits.
- IN is ignored outside a capture. IN_VALID during DRAIN is held off by IN_READY = 0.

## Timing
- Capture at edge k: OUT_VALID = 1 after edge k, so latency from IN handshake to first beat is 1 cycle.
- A vector with N legal bits set needs exactly N output handshakes. With OUT_READY tied high, it drains in N consecutive cycles with no bubbles.
- After the last-beat handshake at edge m, IN_READY = 1 after edge m. The next vector can be captured at edge m+1, giving its first beat after m+1. There is one idle output cycle between vectors.
- Asserting RST mid-DRAIN asynchronously forces the reset values above. Pending bits are discarded and no partial beat is emitted after release.
- The first capture after RST deasserts can happen on the first rising edge.

## Test plan
- Single bit:
  - IN = 0x0000_0400, IN_VALID pulse, OUT_READY = 1 -> one beat with OUT = 10, OUT_LAST = 1, ERR = 0.
  - IN_READY returns to 1 the cycle after that beat.
- Multi-bit, lowest index first:
  - IN = 0x0001_0025, OUT_READY = 1 -> beats OUT = 0, 2, 5, 16 on consecutive cycles.
  - OUT_LAST = 1 only on the beat with OUT = 16.
- Out-of-range and empty:
  - IN = 0x8002_0000 -> EMPTY pulses for 1 cycle, ERR = 1, no beats, IN_READY stays 1.
  - IN = 0x0010_0008 -> one beat OUT = 3 with OUT_LAST = 1, ERR = 1.
- Backpressure:
  - IN = 0x0000_0003, OUT_READY low for 4 cycles -> OUT = 0 and OUT_VALID = 1 held stable for 4 cycles.
  - Then OUT_READY high -> beats OUT = 0, then OUT = 1 with OUT_LAST = 1.
- Reset mid-drain:
  - IN = 0x0000_FFFF, assert RST after the 3rd handshake -> all outputs 0 immediately.
  - After release, IN_READY = 1. A new vector 0x0000_0001 yields a single beat OUT = 0.
- Back-to-back vectors:
  - 0x0000_0006 then 0x0000_0001 with IN_VALID held high and OUT_READY = 1 -> OUT sequence 1, 2, (idle), 0, with OUT_LAST on the 2 and 0 beats.
